// File: rtl/gates_sweeper.sv
// Exhaustive operand sweeper for a 5-function gate stage: steps {b,a} through
// every value, folding each returned result word into a rotating XOR signature.
module gates_sweeper #(
  parameter int unsigned W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             hold,
  output logic [W-1:0]     a,
  output logic [W-1:0]     b,
  input  logic [W-1:0]     y1,
  input  logic [W-1:0]     y2,
  input  logic [W-1:0]     y3,
  input  logic [W-1:0]     y4,
  input  logic [W-1:0]     y5,
  output logic             busy,
  output logic             done,
  output logic [2*W-1:0]   idx,
  output logic [5*W-1:0]   sig
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2*W-1:0]   idx_q, idx_d;
  logic [5*W-1:0]   sig_q, sig_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      sig_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sig_q   <= sig_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sig_d   = sig_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          idx_d   = '0;
          sig_d   = '0;
        end
      end
      S_RUN: begin
        // start is deliberately ignored here; hold freezes everything
        if (!hold) begin
          sig_d = {sig_q[5*W-2:0], sig_q[5*W-1]} ^ {y5, y4, y3, y2, y1};
          idx_d = idx_q + (2*W)'(1);
          if (idx_q == '1) begin
            state_d = S_DONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        sig_d   = '0;
      end
    endcase
  end

  assign a    = idx_q[W-1:0];
  assign b    = idx_q[2*W-1:W];
  assign idx  = idx_q;
  assign sig  = sig_q;
  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_gates_sweeper.sv
// Directed bench for gates_sweeper (W=2) with a selectable gate-stage source.
module tb_gates_sweeper;

  localparam int unsigned W = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           hold;
  logic [W-1:0]   a, b;
  logic [W-1:0]   y1, y2, y3, y4, y5;
  logic           busy, done;
  logic [2*W-1:0] idx;
  logic [5*W-1:0] sig;

  // 0: real gates, 1: y1=01 others 0, 2: all zero
  int unsigned mode;

  int checks   = 0;
  int failures = 0;

  gates_sweeper #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .hold  (hold),
    .a     (a),
    .b     (b),
    .y1    (y1),
    .y2    (y2),
    .y3    (y3),
    .y4    (y4),
    .y5    (y5),
    .busy  (busy),
    .done  (done),
    .idx   (idx),
    .sig   (sig)
  );

  always #5 clk = ~clk;

  always_comb begin
    y1 = '0; y2 = '0; y3 = '0; y4 = '0; y5 = '0;
    if (mode == 0) begin
      y1 = a & b;
      y2 = a | b;
      y3 = a ^ b;
      y4 = ~(a & b);
      y5 = ~(a | b);
    end else if (mode == 1) begin
      y1 = 2'b01;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5*W-1:0] ref_sig();
    logic [5*W-1:0] s;
    logic [W-1:0]   ra, rb;
    logic [3:0]     i4;
    s = '0;
    for (int i = 0; i < 16; i++) begin
      i4 = 4'(i);
      ra = i4[1:0];
      rb = i4[3:2];
      s = {s[8:0], s[9]} ^ {~(ra | rb), ~(ra & rb), ra ^ rb, ra | rb, ra & rb};
    end
    return s;
  endfunction

  logic [5*W-1:0] sig_first, sig_frozen, ref_real;

  initial begin
    mode  = 1;
    start = 1'b0;
    hold  = 1'b0;
    reset = 1'b1;
    ref_real = ref_sig();
    #2;
    check_val("rst_idx",  32'(idx),  0);
    check_val("rst_sig",  32'(sig),  0);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_done", 32'(done), 0);
    check_val("rst_ab",   32'({b, a}), 0);
    @(negedge clk);
    reset = 1'b0;
    hold  = 1'b1;
    tick();
    hold = 1'b0;
    check_val("idle_stay", 32'(busy), 0);

    // basic sweep, y1=01 only
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("e0_busy", 32'(busy), 1);
    check_val("e0_idx",  32'(idx),  0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k < 16) begin
        check_val($sformatf("step_idx%0d", k), 32'(idx), 32'(k));
        check_val($sformatf("step_ab%0d", k), 32'({b, a}), 32'(k));
        check_val($sformatf("step_busy%0d", k), 32'(busy), 1);
      end
    end
    check_val("sw1_done", 32'(done), 1);
    check_val("sw1_busy", 32'(busy), 0);
    check_val("sw1_idx",  32'(idx),  0);
    check_val("sw1_sig",  32'(sig),  32'h3C0);
    hold = 1'b1;
    tick(); tick();
    hold = 1'b0;
    check_val("done_level", 32'(done), 1);
    check_val("done_sig",   32'(sig),  32'h3C0);
    check_val("done_ab",    32'({b, a}), 0);

    // all-zero y inputs
    mode  = 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("zero_clr", 32'(sig), 0);
    repeat (16) tick();
    check_val("zero_done", 32'(done), 1);
    check_val("zero_sig",  32'(sig),  0);

    // real gates, then restart from DONE
    mode  = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (16) tick();
    check_val("real_done", 32'(done), 1);
    check_val("real_sig",  32'(sig),  32'(ref_real));
    sig_first = sig;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("rs_sig",  32'(sig),  0);
    check_val("rs_idx",  32'(idx),  0);
    check_val("rs_busy", 32'(busy), 1);
    repeat (16) tick();
    check_val("rs_done", 32'(done), 1);
    check_val("rs_same", 32'(sig),  32'(sig_first));

    // stall at idx=7 for 5 cycles, start also high during one held cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    check_val("st_idx7", 32'(idx), 7);
    sig_frozen = sig;
    hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      start = (k == 2);
      tick();
      check_val($sformatf("st_idx_h%0d", k), 32'(idx), 7);
      check_val($sformatf("st_sig_h%0d", k), 32'(sig), 32'(sig_frozen));
      check_val($sformatf("st_busy_h%0d", k), 32'(busy), 1);
    end
    hold  = 1'b0;
    start = 1'b0;
    repeat (8) tick();
    check_val("st_not_yet", 32'(done), 0);
    tick();
    check_val("st_done", 32'(done), 1);
    check_val("st_sig",  32'(sig),  32'(ref_real));

    // start in RUN ignored; async reset mid-sweep
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check_val("sr_idx4", 32'(idx), 4);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("sr_ignored", 32'(idx), 5);
    repeat (4) tick();
    check_val("sr_idx9", 32'(idx), 9);
    #2;
    reset = 1'b1;
    #1;
    check_val("ar_idx",  32'(idx),  0);
    check_val("ar_sig",  32'(sig),  0);
    check_val("ar_busy", 32'(busy), 0);
    check_val("ar_done", 32'(done), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) tick();
    check_val("ar_idle", 32'(busy), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("ar_first_start", 32'(busy), 1);
    tick();
    check_val("ar_first_idx", 32'(idx), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
